// File: rtl/l2_request_arbiter_pkg.sv
// Shared L2 request definitions: core count, core index width, request op
// codes and the registered packet layout used by the L2 front-end arbiter.
package l2_request_arbiter_pkg;

  localparam int L2_NUM_CORES     = 2;
  localparam int CORE_INDEX_WIDTH = (L2_NUM_CORES > 1) ? $clog2(L2_NUM_CORES) : 1;

  localparam logic [2:0] L2REQ_LOAD        = 3'd0;
  localparam logic [2:0] L2REQ_STORE       = 3'd1;
  localparam logic [2:0] L2REQ_FLUSH       = 3'd2;
  localparam logic [2:0] L2REQ_INVALIDATE  = 3'd3;
  localparam logic [2:0] L2REQ_SYNCLOAD    = 3'd4;
  localparam logic [2:0] L2REQ_SYNCSTORE   = 3'd5;
  localparam logic [2:0] L2REQ_IINVALIDATE = 3'd6;
  localparam logic [2:0] L2REQ_DINVALIDATE = 3'd7;

  typedef struct packed {
    logic [CORE_INDEX_WIDTH-1:0] core;
    logic [1:0]                  unit;
    logic [1:0]                  strand;
    logic [1:0]                  way;
    logic [2:0]                  op;
    logic [25:0]                 address;
    logic [511:0]                data;
    logic [63:0]                 mask;
    logic                        is_restart;
  } l2_pkt_t;

endpackage

// File: rtl/l2_request_arbiter_rr.sv
// Combinational round-robin arbiter.
// Ports:
//   i_req   - N request lines
//   i_ptr   - index of the highest-priority request this cycle
//   o_grant - one-hot grant of the first active request at or after i_ptr
//             (wrapping), all zero when no request is active
module rr_arbiter #(
  parameter int N     = 2,
  parameter int PTR_W = 1
) (
  input  logic [N-1:0]     i_req,
  input  logic [PTR_W-1:0] i_ptr,
  output logic [N-1:0]     o_grant
);

  logic w_found;

  always_comb begin
    o_grant = '0;
    w_found = 1'b0;
    for (int off = 0; off < N; off++) begin
      for (int i = 0; i < N; i++) begin
        if (!w_found && i_req[i] && (i == ((int'(i_ptr) + off) % N))) begin
          o_grant[i] = 1'b1;
          w_found    = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/l2_request_arbiter.sv
// L2 pipeline front end. Picks one request per cycle from the core request
// ports and the SMI fill restart port, acks it combinationally and registers
// the selected packet into the first pipeline stage.
// Ports:
//   clk, reset            - clock, async active-high reset
//   l2req_*               - per-core request ports (packed, core i at slice i)
//   l2req_ack             - one-hot core accept, same cycle
//   restart_*             - fill restart request and its original fields
//   restart_ack           - restart accept, same cycle
//   stall_pipeline        - downstream busy: freeze outputs, grant nothing
//   arb_*                 - registered packet to the next stage
module l2_request_arbiter
  import l2_request_arbiter_pkg::*;
#(
  parameter int NUM_CORES         = L2_NUM_CORES,
  parameter int RESTART_BURST_MAX = 4
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [NUM_CORES-1:0]          l2req_valid,
  input  logic [NUM_CORES*2-1:0]        l2req_unit,
  input  logic [NUM_CORES*2-1:0]        l2req_strand,
  input  logic [NUM_CORES*3-1:0]        l2req_op,
  input  logic [NUM_CORES*2-1:0]        l2req_way,
  input  logic [NUM_CORES*26-1:0]       l2req_address,
  input  logic [NUM_CORES*512-1:0]      l2req_data,
  input  logic [NUM_CORES*64-1:0]       l2req_mask,
  output logic [NUM_CORES-1:0]          l2req_ack,
  input  logic                          restart_valid,
  input  logic [CORE_INDEX_WIDTH-1:0]   restart_core,
  input  logic [1:0]                    restart_unit,
  input  logic [1:0]                    restart_strand,
  input  logic [1:0]                    restart_way,
  input  logic [2:0]                    restart_op,
  input  logic [25:0]                   restart_address,
  input  logic [511:0]                  restart_data,
  input  logic [63:0]                   restart_mask,
  output logic                          restart_ack,
  input  logic                          stall_pipeline,
  output logic                          arb_l2req_valid,
  output logic [CORE_INDEX_WIDTH-1:0]   arb_l2req_core,
  output logic [1:0]                    arb_l2req_unit,
  output logic [1:0]                    arb_l2req_strand,
  output logic [1:0]                    arb_l2req_way,
  output logic [2:0]                    arb_l2req_op,
  output logic [25:0]                   arb_l2req_address,
  output logic [511:0]                  arb_l2req_data,
  output logic [63:0]                   arb_l2req_mask,
  output logic                          arb_is_restart
);

  localparam int                 BURST_W     = $clog2(RESTART_BURST_MAX + 1);
  localparam logic [BURST_W-1:0] BURST_LIMIT = BURST_W'(RESTART_BURST_MAX);

  logic [CORE_INDEX_WIDTH-1:0] r_rr_ptr;
  logic [BURST_W-1:0]          r_burst_count;
  logic                        r_valid;
  l2_pkt_t                     r_pkt;

  logic [NUM_CORES-1:0]        w_rr_grant;
  logic                        w_enable;
  logic                        w_any_core;
  logic                        w_burst_ok;
  logic                        w_grant_restart;
  logic                        w_grant_core;
  logic [CORE_INDEX_WIDTH-1:0] w_grant_idx;
  logic [CORE_INDEX_WIDTH-1:0] w_next_rr;
  l2_pkt_t                     w_core_pkt;
  l2_pkt_t                     w_restart_pkt;

  rr_arbiter #(
    .N     (NUM_CORES),
    .PTR_W (CORE_INDEX_WIDTH)
  ) u_rr (
    .i_req   (l2req_valid),
    .i_ptr   (r_rr_ptr),
    .o_grant (w_rr_grant)
  );

  assign w_enable   = !reset && !stall_pipeline;
  assign w_any_core = |l2req_valid;
  assign w_burst_ok = (r_burst_count < BURST_LIMIT);

  // Restart wins while under the burst bound; past the bound it only wins
  // when no core is waiting, so an idle core side never blocks fills.
  assign w_grant_restart = w_enable && restart_valid && (w_burst_ok || !w_any_core);
  assign w_grant_core    = w_enable && w_any_core && !w_grant_restart;

  assign l2req_ack   = w_grant_core ? w_rr_grant : '0;
  assign restart_ack = w_grant_restart;

  always_comb begin
    w_core_pkt  = '0;
    w_grant_idx = '0;
    for (int i = 0; i < NUM_CORES; i++) begin
      if (w_rr_grant[i]) begin
        w_grant_idx        = CORE_INDEX_WIDTH'(i);
        w_core_pkt.core    = CORE_INDEX_WIDTH'(i);
        w_core_pkt.unit    = l2req_unit[i*2 +: 2];
        w_core_pkt.strand  = l2req_strand[i*2 +: 2];
        w_core_pkt.way     = l2req_way[i*2 +: 2];
        w_core_pkt.op      = l2req_op[i*3 +: 3];
        w_core_pkt.address = l2req_address[i*26 +: 26];
        w_core_pkt.data    = l2req_data[i*512 +: 512];
        w_core_pkt.mask    = l2req_mask[i*64 +: 64];
      end
    end
  end

  always_comb begin
    w_restart_pkt            = '0;
    w_restart_pkt.core       = restart_core;
    w_restart_pkt.unit       = restart_unit;
    w_restart_pkt.strand     = restart_strand;
    w_restart_pkt.way        = restart_way;
    w_restart_pkt.op         = restart_op;
    w_restart_pkt.address    = restart_address;
    w_restart_pkt.data       = restart_data;
    w_restart_pkt.mask       = restart_mask;
    w_restart_pkt.is_restart = 1'b1;
  end

  assign w_next_rr = (int'(w_grant_idx) + 1 >= NUM_CORES) ? '0 : w_grant_idx + 1'b1;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_rr_ptr      <= '0;
      r_burst_count <= '0;
      r_valid       <= 1'b0;
      r_pkt         <= '0;
    end else if (!stall_pipeline) begin
      r_valid <= w_grant_restart || w_grant_core;
      if (w_grant_restart) begin
        r_pkt <= w_restart_pkt;
      end else if (w_grant_core) begin
        r_pkt    <= w_core_pkt;
        r_rr_ptr <= w_next_rr;
      end
      // The burst only counts restarts that actually held off a core.
      if (w_grant_core || !w_any_core) begin
        r_burst_count <= '0;
      end else if (w_grant_restart && (r_burst_count != BURST_LIMIT)) begin
        r_burst_count <= r_burst_count + 1'b1;
      end
    end
  end

  assign arb_l2req_valid   = r_valid;
  assign arb_l2req_core    = r_pkt.core;
  assign arb_l2req_unit    = r_pkt.unit;
  assign arb_l2req_strand  = r_pkt.strand;
  assign arb_l2req_way     = r_pkt.way;
  assign arb_l2req_op      = r_pkt.op;
  assign arb_l2req_address = r_pkt.address;
  assign arb_l2req_data    = r_pkt.data;
  assign arb_l2req_mask    = r_pkt.mask;
  assign arb_is_restart    = r_pkt.is_restart;

endmodule

// File: tb/tb_l2_request_arbiter.sv
module tb_l2_request_arbiter;
  import l2_request_arbiter_pkg::*;

  localparam int NC = 2;
  localparam int BMAX = 4;

  logic            clk = 1'b0;
  logic            reset;
  logic [NC-1:0]   l2req_valid;
  logic [NC*2-1:0] l2req_unit, l2req_strand, l2req_way;
  logic [NC*3-1:0] l2req_op;
  logic [NC*26-1:0]  l2req_address;
  logic [NC*512-1:0] l2req_data;
  logic [NC*64-1:0]  l2req_mask;
  logic [NC-1:0]   l2req_ack;
  logic            restart_valid;
  logic [0:0]      restart_core;
  logic [1:0]      restart_unit, restart_strand, restart_way;
  logic [2:0]      restart_op;
  logic [25:0]     restart_address;
  logic [511:0]    restart_data;
  logic [63:0]     restart_mask;
  logic            restart_ack;
  logic            stall_pipeline;
  logic            arb_l2req_valid;
  logic [0:0]      arb_l2req_core;
  logic [1:0]      arb_l2req_unit, arb_l2req_strand, arb_l2req_way;
  logic [2:0]      arb_l2req_op;
  logic [25:0]     arb_l2req_address;
  logic [511:0]    arb_l2req_data;
  logic [63:0]     arb_l2req_mask;
  logic            arb_is_restart;

  l2_request_arbiter dut (
    .clk(clk), .reset(reset),
    .l2req_valid(l2req_valid), .l2req_unit(l2req_unit), .l2req_strand(l2req_strand),
    .l2req_op(l2req_op), .l2req_way(l2req_way), .l2req_address(l2req_address),
    .l2req_data(l2req_data), .l2req_mask(l2req_mask), .l2req_ack(l2req_ack),
    .restart_valid(restart_valid), .restart_core(restart_core), .restart_unit(restart_unit),
    .restart_strand(restart_strand), .restart_way(restart_way), .restart_op(restart_op),
    .restart_address(restart_address), .restart_data(restart_data), .restart_mask(restart_mask),
    .restart_ack(restart_ack), .stall_pipeline(stall_pipeline),
    .arb_l2req_valid(arb_l2req_valid), .arb_l2req_core(arb_l2req_core),
    .arb_l2req_unit(arb_l2req_unit), .arb_l2req_strand(arb_l2req_strand),
    .arb_l2req_way(arb_l2req_way), .arb_l2req_op(arb_l2req_op),
    .arb_l2req_address(arb_l2req_address), .arb_l2req_data(arb_l2req_data),
    .arb_l2req_mask(arb_l2req_mask), .arb_is_restart(arb_is_restart)
  );

  always #5 clk = ~clk;

  // One requester: indices 0..NC-1 are cores, index NC is the restart port.
  typedef struct {
    logic         v;
    logic [0:0]   core;
    logic [1:0]   unit, strand, way;
    logic [2:0]   op;
    logic [25:0]  addr;
    logic [511:0] data;
    logic [63:0]  mask;
  } src_t;

  typedef struct {
    logic [1:0] v;
    logic       r;
    logic       s;
    logic [1:0] ack;
    logic       rack;
    logic       pv;
    logic [0:0] pcore;
    logic       prs;
  } vec_t;

  src_t src[NC+1];
  vec_t tbl[26];
  int   n_cmp = 0;
  int   n_err = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic drive();
    for (int i = 0; i < NC; i++) begin
      l2req_valid[i]            = src[i].v;
      l2req_unit[i*2 +: 2]      = src[i].unit;
      l2req_strand[i*2 +: 2]    = src[i].strand;
      l2req_way[i*2 +: 2]       = src[i].way;
      l2req_op[i*3 +: 3]        = src[i].op;
      l2req_address[i*26 +: 26] = src[i].addr;
      l2req_data[i*512 +: 512]  = src[i].data;
      l2req_mask[i*64 +: 64]    = src[i].mask;
    end
    restart_valid   = src[NC].v;
    restart_core    = src[NC].core;
    restart_unit    = src[NC].unit;
    restart_strand  = src[NC].strand;
    restart_way     = src[NC].way;
    restart_op      = src[NC].op;
    restart_address = src[NC].addr;
    restart_data    = src[NC].data;
    restart_mask    = src[NC].mask;
  endtask

  task automatic chk_pkt(input string tag, input src_t e, input logic [0:0] core, input logic rs);
    chk({tag, "_core"}, 64'(arb_l2req_core), 64'(core));
    chk({tag, "_unit"}, 64'({arb_l2req_unit, arb_l2req_strand, arb_l2req_way}),
        64'({e.unit, e.strand, e.way}));
    chk({tag, "_op"}, 64'(arb_l2req_op), 64'(e.op));
    chk({tag, "_addr"}, 64'(arb_l2req_address), 64'(e.addr));
    chk({tag, "_mask"}, arb_l2req_mask, e.mask);
    chk({tag, "_data_eq"}, 64'(arb_l2req_data == e.data), 64'd1);
    chk({tag, "_is_restart"}, 64'(arb_is_restart), 64'(rs));
  endtask

  function automatic src_t rand_src(int k);
    src_t s;
    s.v      = 1'b1;
    s.core   = (k == NC) ? 1'($urandom_range(0, 1)) : 1'(k);
    s.unit   = 2'($urandom);
    s.strand = 2'($urandom);
    s.way    = 2'($urandom);
    s.op     = 3'($urandom);
    s.addr   = 26'($urandom);
    for (int w = 0; w < 16; w++) s.data[w*32 +: 32] = $urandom;
    s.mask   = {$urandom, $urandom};
    return s;
  endfunction

  // Reference model state
  int   m_rr, m_burst, g, prev_g;
  logic any_core;
  src_t exp_s;
  logic exp_valid, exp_rs;
  logic [0:0] exp_core;

  initial begin
    // v, r, s, ack, rack, pv, pcore, prs  (restart source reports core 1)
    tbl = '{
      '{2'b01,1'b0,1'b0,2'b01,1'b0,1'b1,1'b0,1'b0},
      '{2'b10,1'b0,1'b0,2'b10,1'b0,1'b1,1'b1,1'b0},
      '{2'b11,1'b0,1'b0,2'b01,1'b0,1'b1,1'b0,1'b0},
      '{2'b11,1'b0,1'b0,2'b10,1'b0,1'b1,1'b1,1'b0},
      '{2'b11,1'b0,1'b0,2'b01,1'b0,1'b1,1'b0,1'b0},
      '{2'b11,1'b0,1'b0,2'b10,1'b0,1'b1,1'b1,1'b0},
      '{2'b10,1'b1,1'b0,2'b00,1'b1,1'b1,1'b1,1'b1},
      '{2'b10,1'b1,1'b0,2'b00,1'b1,1'b1,1'b1,1'b1},
      '{2'b10,1'b1,1'b0,2'b00,1'b1,1'b1,1'b1,1'b1},
      '{2'b10,1'b1,1'b0,2'b00,1'b1,1'b1,1'b1,1'b1},
      '{2'b10,1'b1,1'b0,2'b10,1'b0,1'b1,1'b1,1'b0},
      '{2'b10,1'b1,1'b0,2'b00,1'b1,1'b1,1'b1,1'b1},
      '{2'b11,1'b1,1'b1,2'b00,1'b0,1'b1,1'b1,1'b1},
      '{2'b11,1'b1,1'b1,2'b00,1'b0,1'b1,1'b1,1'b1},
      '{2'b11,1'b1,1'b1,2'b00,1'b0,1'b1,1'b1,1'b1},
      '{2'b11,1'b1,1'b0,2'b00,1'b1,1'b1,1'b1,1'b1},
      '{2'b11,1'b1,1'b0,2'b00,1'b1,1'b1,1'b1,1'b1},
      '{2'b11,1'b1,1'b0,2'b00,1'b1,1'b1,1'b1,1'b1},
      '{2'b11,1'b1,1'b0,2'b01,1'b0,1'b1,1'b0,1'b0},
      '{2'b11,1'b1,1'b0,2'b00,1'b1,1'b1,1'b1,1'b1},
      '{2'b01,1'b1,1'b0,2'b00,1'b1,1'b1,1'b1,1'b1},
      '{2'b01,1'b1,1'b0,2'b00,1'b1,1'b1,1'b1,1'b1},
      '{2'b01,1'b1,1'b0,2'b00,1'b1,1'b1,1'b1,1'b1},
      '{2'b00,1'b1,1'b0,2'b00,1'b1,1'b1,1'b1,1'b1},
      '{2'b01,1'b1,1'b0,2'b00,1'b1,1'b1,1'b1,1'b1},
      '{2'b00,1'b0,1'b0,2'b00,1'b0,1'b0,1'b0,1'b0}
    };

    src[0] = rand_src(0); src[0].op = L2REQ_LOAD;  src[0].addr = 26'h123;
    src[1] = rand_src(1); src[1].op = L2REQ_STORE; src[1].addr = 26'h2AB;
    src[2] = rand_src(2); src[2].core = 1'b1; src[2].op = L2REQ_FLUSH; src[2].addr = 26'h3FF00;

    // Reset with everything requesting: no acks, outputs cleared
    reset = 1'b1;
    stall_pipeline = 1'b0;
    drive();
    #3;
    chk("rst_ack", 64'({restart_ack, l2req_ack}), 64'd0);
    chk("rst_valid", 64'(arb_l2req_valid), 64'd0);
    @(posedge clk); #1;
    chk("rst_ack_clk", 64'({restart_ack, l2req_ack}), 64'd0);
    chk("rst_outs", 64'({arb_l2req_valid, arb_is_restart, arb_l2req_core, arb_l2req_op}), 64'd0);
    chk("rst_addr", 64'(arb_l2req_address), 64'd0);
    src[0].v = 1'b0; src[1].v = 1'b0; src[2].v = 1'b0;
    drive();
    reset = 1'b0;

    for (int i = 0; i < 26; i++) begin
      src[0].v = tbl[i].v[0];
      src[1].v = tbl[i].v[1];
      src[2].v = tbl[i].r;
      stall_pipeline = tbl[i].s;
      drive();
      #3;
      chk($sformatf("tbl%0d_ack", i), 64'({restart_ack, l2req_ack}), 64'({tbl[i].rack, tbl[i].ack}));
      @(posedge clk); #1;
      chk($sformatf("tbl%0d_valid", i), 64'(arb_l2req_valid), 64'(tbl[i].pv));
      if (tbl[i].pv)
        chk_pkt($sformatf("tbl%0d", i), src[tbl[i].prs ? 2 : int'(tbl[i].pcore)], tbl[i].pcore, tbl[i].prs);
    end

    // Reset in the middle of a transfer: packet dropped, pointer back to 0
    stall_pipeline = 1'b0;
    src[0].v = 1'b1; src[1].v = 1'b0; src[2].v = 1'b0;
    drive();
    #3;
    chk("mid_pre_ack", 64'(l2req_ack), 64'd1);
    @(posedge clk); #1;
    chk("mid_pre_valid", 64'(arb_l2req_valid), 64'd1);
    reset = 1'b1;
    src[1].v = 1'b1;
    drive();
    #1;
    chk("mid_rst_outs", 64'({arb_l2req_valid, arb_is_restart, arb_l2req_core, arb_l2req_op}), 64'd0);
    chk("mid_rst_addr", 64'(arb_l2req_address), 64'd0);
    chk("mid_rst_ack", 64'({restart_ack, l2req_ack}), 64'd0);
    #1;
    reset = 1'b0;
    #1;
    chk("mid_post_ack", 64'({restart_ack, l2req_ack}), 64'b001);
    @(posedge clk); #1;
    chk("mid_post_valid", 64'(arb_l2req_valid), 64'd1);
    chk_pkt("mid_post", src[0], 1'b0, 1'b0);

    // Randomised run against the reference model
    reset = 1'b1;
    for (int k = 0; k <= NC; k++) src[k].v = 1'b0;
    drive();
    #2;
    reset = 1'b0;
    m_rr = 0; m_burst = 0; prev_g = -1;
    exp_valid = 1'b0; exp_rs = 1'b0; exp_core = 1'b0; exp_s = src[0];

    for (int cyc = 0; cyc < 3000; cyc++) begin
      @(posedge clk); #1;
      chk("rnd_valid", 64'(arb_l2req_valid), 64'(exp_valid));
      if (exp_valid) chk_pkt("rnd", exp_s, exp_core, exp_rs);

      if (prev_g >= 0) src[prev_g].v = 1'b0;
      for (int k = 0; k <= NC; k++)
        if (!src[k].v && ($urandom_range(0, 99) < ((k == NC) ? 60 : 45))) src[k] = rand_src(k);
      stall_pipeline = ($urandom_range(0, 99) < 15);
      drive();
      #3;

      any_core = 1'b0;
      for (int k = 0; k < NC; k++) any_core |= src[k].v;
      g = -1;
      if (!stall_pipeline) begin
        if (src[NC].v && m_burst < BMAX) g = NC;
        else if (any_core) begin
          for (int off = NC - 1; off >= 0; off--)
            if (src[(m_rr + off) % NC].v) g = (m_rr + off) % NC;
        end else if (src[NC].v) g = NC;
      end
      chk("rnd_ack", 64'({restart_ack, l2req_ack}),
          64'({g == NC, g == 1, g == 0}));

      if (!stall_pipeline) begin
        if (g == NC) begin
          exp_valid = 1'b1; exp_s = src[NC]; exp_core = src[NC].core; exp_rs = 1'b1;
          m_burst = any_core ? ((m_burst + 1 > BMAX) ? BMAX : m_burst + 1) : 0;
        end else if (g >= 0) begin
          exp_valid = 1'b1; exp_s = src[g]; exp_core = 1'(g); exp_rs = 1'b0;
          m_burst = 0;
          m_rr = (g + 1) % NC;
        end else begin
          exp_valid = 1'b0;
          m_burst = 0;
        end
      end
      prev_g = g;
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
